input_ram_ctrl: RTL and testbench
=================================

Name: input_ram_ctrl

Overview:
- Sequences the single-port input image RAM (1-bit wide, 784 deep) that feeds the SNN core.
- Unpacks bytes received from the UART into consecutive RAM bit locations, then pulses start to snn_core.
- Hands the RAM address port to the core for the inference and latches the classified digit on done.
- Sits between the UART receiver, ram_input_unit and snn_core.

Parameters:
- PIXELS, 784, number of image bits per frame; must be a multiple of 8.
- ADDR_W, 10, RAM address width; 2^ADDR_W >= PIXELS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received UART byte; valid only when rx_rdy is high.
- rx_rdy  input  1  single-cycle strobe; a new byte is present on rx_data.
- core_addr  input  ADDR_W  read address from snn_core.
- core_done  input  1  single-cycle strobe from snn_core; inference complete.
- core_digit  input  4  classification result; valid with core_done.
- ram_addr  output  ADDR_W  address to ram_input_unit.
- ram_we  output  1  RAM write enable.
- ram_d  output  1  RAM write data bit.
- core_start  output  1  single-cycle start strobe to snn_core.
- digit  output  4  last latched result.
- digit_vld  output  1  single-cycle strobe; digit updated.
- busy  output  1  high in UNPACK, START and RUN.
- overrun  output  1  sticky; a byte was dropped since reset.

Behaviour:
- Reset values: ram_addr=0, ram_we=0, ram_d=0, core_start=0, digit=0, digit_vld=0, busy=0, overrun=0. State is LOAD, bit pointer is 0, and the hold register is empty.
- Reset is asynchronous, and all state returns to the reset values immediately, including during UNPACK or RUN.
- States: LOAD, UNPACK, START and RUN.
- LOAD
  - Waits for a byte.
  - If rx_rdy is high, or the hold register is full, the byte moves into a shift register and the state goes to UNPACK.
  - A held byte takes priority over a simultaneous rx_rdy, which then goes into the hold register.
- UNPACK
  - Runs for 8 cycles, one bit per cycle, LSB first.
  - Each cycle: ram_we=1, ram_d=current bit, ram_addr=bit pointer; the bit pointer then increments.
  - After the 8th bit:
    - If pointer == PIXELS: pointer clears to 0 and the state goes to START.
    - Else, if the hold register is full: its byte loads and UNPACK continues with no gap cycle.
    - Otherwise the state goes to LOAD.
- Hold register during UNPACK
  - rx_rdy in UNPACK while the hold register is empty stores the byte in the hold register.
  - rx_rdy while the hold register is full drops the byte and sets overrun.
- START
  - Lasts one cycle.
  - core_start=1, ram_we=0, and the state goes to RUN.
  - Latency: core_start is high exactly one cycle after the write of address PIXELS-1.
- RUN
  - ram_addr follows core_addr combinationally (mux select is state==RUN); ram_we=0.
  - rx_rdy is ignored and sets overrun.
  - The hold register must be empty on entry; a byte left in it at START is discarded and sets overrun.
  - On core_done: digit <= core_digit, digit_vld=1 for one cycle, and the state goes to LOAD.
- Outside RUN, ram_addr is driven from the bit pointer, and ram_we is high only in UNPACK.
- Arithmetic
  - Bit pointer is ADDR_W bits and never exceeds PIXELS.
  - Frame byte count is PIXELS/8 = 98 bytes.
- core_done outside RUN is ignored.
- overrun clears only on rst.

Decomposition:
- Package snn_pkg holds: the state enum (LOAD, UNPACK, START, RUN), PIXELS_DEF=784, ADDR_W_DEF=10 and DIGIT_W=4.
- Sub-module byte_unpacker is natural: shift register, bit counter and one-byte hold register, with a byte-done and bit-valid interface.
- The FSM, address mux and result latch stay in the top level.

Test Plan:
- Full frame:
  - Stimulus: 98 bytes where byte k = k[7:0], rx_rdy spaced 20 cycles apart.
  - Response: RAM model holds bit (k*8+i) = bit i of k for all 784 addresses.
  - core_start is high exactly once, one cycle after the addr 783 write; busy stays high until core_done.
- Back-to-back bytes:
  - Stimulus: rx_rdy every 8 cycles with 0xA5 and 0x3C.
  - Response: continuous writes with no gap cycle; addrs 0-7 = 1,0,1,0,0,1,0,1; addrs 8-15 = 0,0,1,1,1,1,0,0.
  - overrun stays 0.
- Overrun:
  - Stimulus: three rx_rdy on consecutive cycles with 0x01, 0x02, 0x03.
  - Response: 0x01 and 0x02 are written to addrs 0-15; 0x03 is dropped and overrun=1 from the next cycle.
- Inference handoff:
  - Stimulus: after START, drive core_addr=0x123, then core_done with core_digit=7.
  - Response: ram_addr=0x123 in the same cycle and ram_we=0.
  - On core_done: digit=7 and digit_vld pulses one cycle; the state returns to LOAD and the next byte writes addr 0.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after 40 bytes, mid-UNPACK.
  - Response: all outputs reach reset values without waiting for a clock edge.
  - A full 98-byte frame afterwards starts at addr 0 and completes normally.
- Ignored input:
  - Stimulus: core_done while in LOAD, and rx_rdy while in RUN.
  - Response: digit_vld stays 0 and digit is unchanged; the rx_rdy in RUN sets overrun and causes no RAM write.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN input path.
// Holds the controller state enum and default frame geometry.
package snn_pkg;

  typedef enum logic [1:0] {
    LOAD,
    UNPACK,
    START,
    RUN
  } state_t;

  localparam int PIXELS_DEF = 784;
  localparam int ADDR_W_DEF = 10;
  localparam int DIGIT_W    = 4;

endpackage

// File: rtl/byte_unpacker.sv
// Byte-to-bit unpacker: shift register, bit counter, one-byte hold.
// Ports: rx byte/strobe in; phase controls from the FSM; bit stream,
//        byte_done/byte_load handshakes and a drop pulse out.
module byte_unpacker (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       idle,
  input  logic       shift_en,
  input  logic       frame_end,
  input  logic       flush,
  output logic       bit_d,
  output logic       bit_vld,
  output logic       byte_done,
  output logic       byte_load,
  output logic       drop
);

  logic [7:0] sreg;
  logic [7:0] hold;
  logic       hold_full;
  logic [2:0] cnt;
  logic       want;
  logic       rx_open;
  logic       hold_store;

  assign bit_vld   = shift_en;
  assign bit_d     = sreg[0];
  assign byte_done = shift_en && (cnt == 3'd7);
  assign want      = hold_full || rx_rdy;
  assign rx_open   = idle || shift_en;

  // A byte starts unpacking from LOAD, or back-to-back at the end
  // of a byte unless that byte closes the frame.
  assign byte_load = want && (idle || (byte_done && !frame_end));

  always_comb begin
    hold_store = 1'b0;
    drop       = 1'b0;
    if (rx_rdy) begin
      if (byte_load && !hold_full) begin
        // incoming byte goes straight into the shift register
        hold_store = 1'b0;
      end else if (rx_open && (!hold_full || byte_load)) begin
        hold_store = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    // a byte still held when the core starts is lost
    if (flush && hold_full) begin
      drop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (flush) begin
      hold_full <= 1'b0;
    end else if (hold_store) begin
      hold      <= rx_data;
      hold_full <= 1'b1;
    end else if (byte_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (byte_load) begin
      sreg <= hold_full ? hold : rx_data;
      cnt  <= '0;
    end else if (shift_en) begin
      sreg <= {1'b0, sreg[7:1]};
      cnt  <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/input_ram_ctrl.sv
// Input image RAM sequencer: unpacks UART bytes into the bit RAM,
// starts snn_core, hands it the address port and latches the digit.
// Ports: UART rx in, core addr/done/digit in; RAM addr/we/d,
//        core_start, digit/digit_vld, busy and sticky overrun out.
module input_ram_ctrl
  import snn_pkg::*;
#(
  parameter int PIXELS = PIXELS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_rdy,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic               core_done,
  input  logic [DIGIT_W-1:0] core_digit,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_we,
  output logic               ram_d,
  output logic               core_start,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_vld,
  output logic               busy,
  output logic               overrun
);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] ptr;
  logic              frame_end;
  logic              bit_d;
  logic              bit_vld;
  logic              byte_done;
  logic              byte_load;
  logic              drop;

  assign frame_end = (ptr == ADDR_W'(PIXELS - 1));

  byte_unpacker u_unp (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .idle      (state == LOAD),
    .shift_en  (state == UNPACK),
    .frame_end (frame_end),
    .flush     (state == START),
    .bit_d     (bit_d),
    .bit_vld   (bit_vld),
    .byte_done (byte_done),
    .byte_load (byte_load),
    .drop      (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      LOAD: begin
        if (byte_load) nxt = UNPACK;
      end
      UNPACK: begin
        if (byte_done) begin
          if (frame_end)       nxt = START;
          else if (!byte_load) nxt = LOAD;
        end
      end
      START: begin
        nxt = RUN;
      end
      RUN: begin
        if (core_done) nxt = LOAD;
      end
      default: nxt = LOAD;
    endcase
  end

  // pointer wraps to 0 on the last pixel, ready for the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == UNPACK) begin
      ptr <= frame_end ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit     <= '0;
      digit_vld <= 1'b0;
    end else begin
      digit_vld <= 1'b0;
      if (state == RUN && core_done) begin
        digit     <= core_digit;
        digit_vld <= 1'b1;
      end
    end
  end

  assign ram_addr   = (state == RUN) ? core_addr : ptr;
  assign ram_we     = bit_vld;
  assign ram_d      = bit_d;
  assign core_start = (state == START);
  assign busy       = (state != LOAD);

endmodule

// File: tb/tb_input_ram_ctrl.sv
// Self-checking bench for input_ram_ctrl.
// Scoreboard of expected RAM writes plus directed protocol checks.
module tb_input_ram_ctrl;

  localparam int PIX = 784;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_rdy = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic          core_done = 1'b0;
  logic [3:0]    core_digit = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_d;
  logic          core_start;
  logic [3:0]    digit;
  logic          digit_vld;
  logic          busy;
  logic          overrun;

  input_ram_ctrl #(.PIXELS(PIX), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .core_addr  (core_addr),
    .core_done  (core_done),
    .core_digit (core_digit),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_d      (ram_d),
    .core_start (core_start),
    .digit      (digit),
    .digit_vld  (digit_vld),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [AW:0]   exp_q[$];
  logic          ram_model [0:1023];
  int            exp_ptr = 0;
  int            cyc = 0;
  int            last783 = -10;
  int            start_cyc = -10;
  int            start_cnt = 0;
  int            run_len = 0;
  int            max_run = 0;

  // write monitor: every RAM write must match the scoreboard head
  always @(negedge clk) begin
    logic [AW:0] e;
    cyc++;
    if (ram_we) begin
      if (exp_q.size() == 0) begin
        check("wr_unexp", 32'(ram_addr), 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_addr), 32'(e[AW:1]));
        check("wr_bit", 32'(ram_d), 32'(e[0]));
      end
      ram_model[ram_addr] = ram_d;
      if (ram_addr == AW'(PIX - 1)) last783 = cyc;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (core_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({AW'(exp_ptr + i), b[i]});
    end
    exp_ptr = (exp_ptr + 8) % PIX;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    push_byte(b);
    @(negedge clk);
    rx_rdy  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("q_drain", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ptr = 0;
  endtask

  // full 98-byte frame, byte k = k, one byte every 20 cycles
  task automatic send_frame();
    int s0;
    int bad;
    s0 = start_cnt;
    for (int k = 0; k < PIX / 8; k++) begin
      send_byte(8'(k));
      repeat (18) @(negedge clk);
    end
    for (int i = 0; i < 100 && start_cnt == s0; i++) @(negedge clk);
    check("start_once", 32'(start_cnt - s0), 1);
    check("start_lat", 32'(start_cyc - last783), 1);
    check("busy_run", 32'(busy), 1);
    bad = 0;
    for (int a = 0; a < PIX; a++) begin
      logic [7:0] kb;
      kb = 8'(a / 8);
      if (ram_model[a] !== kb[a % 8]) bad++;
    end
    check("ram_frame", 32'(bad), 0);
    check("frame_q", 32'(exp_q.size()), 0);
  endtask

  task automatic finish_run(input logic [3:0] d);
    @(negedge clk);
    core_digit = d;
    core_done  = 1'b1;
    @(negedge clk);
    core_done  = 1'b0;
    check("dig_val", 32'(digit), 32'(d));
    check("dig_vld", 32'(digit_vld), 1);
    check("busy_done", 32'(busy), 0);
    @(negedge clk);
    check("dig_vld_1", 32'(digit_vld), 0);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ram_model[a] = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_outs", {ram_we, ram_d, core_start, digit_vld,
                       busy, overrun}, 0);
    check("rst_digit", 32'(digit), 0);
    @(negedge clk);
    rst = 1'b0;

    // core_done in LOAD is ignored
    @(negedge clk);
    core_digit = 4'd5;
    core_done  = 1'b1;
    @(negedge clk);
    core_done  = 1'b0;
    check("ign_vld", 32'(digit_vld), 0);
    check("ign_dig", 32'(digit), 0);
    check("ign_busy", 32'(busy), 0);

    // back-to-back bytes, no gap cycle
    max_run = 0;
    send_byte(8'hA5);
    repeat (6) @(negedge clk);
    send_byte(8'h3C);
    wait_drain();
    check("b2b_run", 32'(max_run), 16);
    check("b2b_ovr", 32'(overrun), 0);

    // overrun: three strobes on consecutive cycles
    do_reset();
    @(negedge clk);
    rx_data = 8'h01;
    rx_rdy  = 1'b1;
    push_byte(8'h01);
    @(negedge clk);
    rx_data = 8'h02;
    push_byte(8'h02);
    @(negedge clk);
    rx_data = 8'h03;
    check("ovr_pre", 32'(overrun), 0);
    @(negedge clk);
    rx_rdy  = 1'b0;
    check("ovr_set", 32'(overrun), 1);
    wait_drain();
    repeat (4) @(negedge clk);
    check("ovr_idle", 32'(busy), 0);
    check("ovr_q", 32'(exp_q.size()), 0);

    // full frame then inference handoff
    do_reset();
    check("ovr_clr", 32'(overrun), 0);
    send_frame();
    @(negedge clk);
    core_addr = 10'h123;
    #1;
    check("run_addr", 32'(ram_addr), 32'h123);
    check("run_we", 32'(ram_we), 0);
    check("run_ovr0", 32'(overrun), 0);
    @(negedge clk);
    rx_data = 8'hFF;
    rx_rdy  = 1'b1;
    @(negedge clk);
    rx_rdy  = 1'b0;
    check("run_ovr1", 32'(overrun), 1);
    repeat (3) @(negedge clk);
    check("run_busy", 32'(busy), 1);
    finish_run(4'd7);
    send_byte(8'h5A);
    wait_drain();

    // asynchronous reset mid-UNPACK
    do_reset();
    for (int k = 0; k < 40; k++) begin
      send_byte(8'(k));
      repeat (18) @(negedge clk);
    end
    send_byte(8'd40);
    repeat (2) @(negedge clk);
    check("pre_rst_we", 32'(ram_we), 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", 32'(ram_addr), 0);
    check("arst_outs", {ram_we, ram_d, core_start, digit_vld,
                        busy, overrun}, 0);
    check("arst_dig", 32'(digit), 0);
    exp_q.delete();
    exp_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 1024; a++) ram_model[a] = 1'b0;
    send_frame();
    finish_run(4'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
